// File: rtl/ppu_defines_pkg.sv
// Shared PPU raster types and default NTSC-like geometry.
// Used by ppu_timing_gen (optional feature macro: PPU_ODD_FRAME_SKIP_EN).
package ppu_defines;

    typedef enum logic [1:0] {
        PRE_SL    = 2'd0,
        VIS_SL    = 2'd1,
        POST_SL   = 2'd2,
        VBLANK_SL = 2'd3
    } vs_state_t;

    typedef enum logic [2:0] {
        SL_PRE_CYC = 3'd0,
        IDLE_CYC   = 3'd1,
        SP_PRE_CYC = 3'd2,
        TL_PRE_CYC = 3'd3,
        GARB_CYC   = 3'd4
    } hs_state_t;

    localparam int PPU_CLK_DIV         = 4;
    localparam int PPU_DOTS_PER_LINE   = 341;
    localparam int PPU_VIS_DOTS        = 256;
    localparam int PPU_SP_FETCH_DOTS   = 64;
    localparam int PPU_TL_FETCH_DOTS   = 16;
    localparam int PPU_LINES_PER_FRAME = 262;
    localparam int PPU_VIS_LINES       = 240;

endpackage

// File: rtl/ppu_timing_gen_clk_div.sv
// System-clock divider producing the one-in-CLK_DIV PPU dot enable.
// clk_en is registered; clk_en_next is its value for the following cycle.
module ppu_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic clk_en,
    output logic clk_en_next
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             en_q, en_d;

    always_comb begin
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        en_d = (div_d == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            en_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            en_q  <= en_d;
        end
    end

    assign clk_en      = en_q;
    assign clk_en_next = en_d;

endmodule

// File: rtl/ppu_timing_gen.sv
// PPU raster timing: dot enable, row/col counters, phase decode, vblank and strobes.
// Optional macro PPU_ODD_FRAME_SKIP_EN drops the last dot of row 0 on odd rendered frames.
module ppu_timing_gen
    import ppu_defines::*;
#(
    parameter int CLK_DIV         = PPU_CLK_DIV,
    parameter int DOTS_PER_LINE   = PPU_DOTS_PER_LINE,
    parameter int VIS_DOTS        = PPU_VIS_DOTS,
    parameter int SP_FETCH_DOTS   = PPU_SP_FETCH_DOTS,
    parameter int TL_FETCH_DOTS   = PPU_TL_FETCH_DOTS,
    parameter int LINES_PER_FRAME = PPU_LINES_PER_FRAME,
    parameter int VIS_LINES       = PPU_VIS_LINES,
    parameter int COL_W           = $clog2(DOTS_PER_LINE),
    parameter int ROW_W           = $clog2(LINES_PER_FRAME)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             render_en,
    input  logic             vblank_clr,
    output logic             ppu_clk_en,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output vs_state_t        vs_state,
    output hs_state_t        hs_state,
    output logic             vblank,
    output logic             vblank_set,
    output logic             frame_start,
    output logic             line_start,
    output logic             frame_odd
);

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(DOTS_PER_LINE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(LINES_PER_FRAME - 1);
    localparam logic [ROW_W-1:0] ROW_VBLANK = ROW_W'(VIS_LINES + 2);

    logic             clk_en_s, clk_en_next_s, skip_s;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             frame_odd_q, frame_odd_d;
    vs_state_t        vs_q, vs_d;
    hs_state_t        hs_q, hs_d;
    logic             vblank_q, vblank_d, vblank_set_q, vblank_set_d;
    logic             frame_start_q, frame_start_d, line_start_q, line_start_d;

    function automatic vs_state_t vs_decode(input logic [ROW_W-1:0] r);
        if (int'(r) == 0)                   return PRE_SL;
        else if (int'(r) <= VIS_LINES)      return VIS_SL;
        else if (int'(r) == VIS_LINES + 1)  return POST_SL;
        else                                return VBLANK_SL;
    endfunction

    function automatic hs_state_t hs_decode(input logic [COL_W-1:0] c);
        if (int'(c) < VIS_DOTS)                                      return SL_PRE_CYC;
        else if (int'(c) == VIS_DOTS)                                return IDLE_CYC;
        else if (int'(c) <= VIS_DOTS + SP_FETCH_DOTS)                return SP_PRE_CYC;
        else if (int'(c) <= VIS_DOTS + SP_FETCH_DOTS + TL_FETCH_DOTS) return TL_PRE_CYC;
        else                                                         return GARB_CYC;
    endfunction

    ppu_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en_s),
        .clk_en_next (clk_en_next_s)
    );

`ifdef PPU_ODD_FRAME_SKIP_EN
    assign skip_s = clk_en_s && render_en && frame_odd_q && (row_q == '0)
                    && (col_q == COL_W'(DOTS_PER_LINE - 2));
`else
    logic unused_render_en_s;
    assign unused_render_en_s = render_en;
    assign skip_s             = 1'b0;
`endif

    // Phase states and strobes decode the post-advance position so they line up with row/col.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        frame_odd_d = frame_odd_q;
        if (clk_en_s) begin
            if (skip_s) begin
                col_d = '0;
                row_d = ROW_W'(1);
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d       = '0;
                    frame_odd_d = ~frame_odd_q;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else begin
            col_d = col_q;
        end

        vs_d          = vs_decode(row_d);
        hs_d          = hs_decode(col_d);
        vblank_set_d  = clk_en_s && (row_d == ROW_VBLANK) && (col_d == COL_W'(1));
        line_start_d  = clk_en_next_s && (col_d == '0);
        frame_start_d = line_start_d && (row_d == '0);

        if (vblank_set_d) begin
            vblank_d = 1'b1;
        end else if (vblank_clr || (clk_en_s && (row_d == '0) && (col_d == COL_W'(1)))) begin
            vblank_d = 1'b0;
        end else begin
            vblank_d = vblank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q         <= '0;
            row_q         <= '0;
            frame_odd_q   <= 1'b0;
            vs_q          <= PRE_SL;
            hs_q          <= SL_PRE_CYC;
            vblank_q      <= 1'b0;
            vblank_set_q  <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            frame_odd_q   <= frame_odd_d;
            vs_q          <= vs_d;
            hs_q          <= hs_d;
            vblank_q      <= vblank_d;
            vblank_set_q  <= vblank_set_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign ppu_clk_en  = clk_en_s;
    assign row         = row_q;
    assign col         = col_q;
    assign vs_state    = vs_q;
    assign hs_state    = hs_q;
    assign vblank      = vblank_q;
    assign vblank_set  = vblank_set_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign frame_odd   = frame_odd_q;

endmodule
